// File: rtl/ball_motion_ctrl.sv
// Ball position/velocity engine: one bounce-checked step per frame edge, with a
// configuration port that may reload velocity and position between updates.
module ball_motion_ctrl #(
    parameter int H_LIMIT   = 320,
    parameter int V_LIMIT   = 240,
    parameter int BALL_SIZE = 4,
    parameter int INIT_H    = 128,
    parameter int INIT_V    = 128,
    parameter int INIT_HVEL = -2,
    parameter int INIT_VVEL = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vsync_i,
    input  logic        run_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [8:0]  cfg_hvel_i,
    input  logic [8:0]  cfg_vvel_i,
    input  logic        cfg_load_pos_i,
    input  logic [8:0]  cfg_hpos_i,
    input  logic [8:0]  cfg_vpos_i,
    output logic [8:0]  ball_hpos_o,
    output logic [8:0]  ball_vpos_o,
    output logic        hit_h_o,
    output logic        hit_v_o,
    output logic        done_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [8:0] HMax = 9'(H_LIMIT - BALL_SIZE);
    localparam logic [8:0] VMax = 9'(V_LIMIT - BALL_SIZE);

    typedef enum logic [0:0] {StIdle, StUpdate} state_e;

    typedef struct packed {
        logic [8:0] pos;
        logic [8:0] vel;
        logic       hit;
    } axis_t;

    // One axis step in 11-bit signed arithmetic; landing exactly on a wall is not a bounce.
    function automatic axis_t axis_step(input logic [8:0] pos, input logic [8:0] vel,
                                        input logic [8:0] max);
        logic signed [10:0] nxt;
        logic signed [10:0] lim;
        axis_t r;
        nxt = $signed({2'b00, pos}) + $signed({{2{vel[8]}}, vel});
        lim = $signed({2'b00, max});
        if (nxt < 11'sd0) begin
            r.pos = 9'd0;
            r.vel = ~vel + 9'd1;
            r.hit = 1'b1;
        end else if (nxt > lim) begin
            r.pos = max;
            r.vel = ~vel + 9'd1;
            r.hit = 1'b1;
        end else begin
            r.pos = nxt[8:0];
            r.vel = vel;
            r.hit = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [8:0] clamp(input logic [8:0] p, input logic [8:0] max);
        return (p > max) ? max : p;
    endfunction

    state_e      state_q, state_d;
    logic        vs_q;
    logic        pend_q, pend_d;
    logic [8:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [8:0]  hvel_q, hvel_d, vvel_q, vvel_d;
    logic        hit_h_q, hit_h_d, hit_v_q, hit_v_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;

    logic  frame_edge;
    logic  xfer;
    axis_t h_step, v_step;

    assign frame_edge = vsync_i & ~vs_q;
    assign xfer       = cfg_valid_i & (state_q == StIdle);
    assign h_step     = axis_step(hpos_q, hvel_q, HMax);
    assign v_step     = axis_step(vpos_q, vvel_q, VMax);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        hvel_d  = hvel_q;
        vvel_d  = vvel_q;
        hit_h_d = 1'b0;
        hit_v_d = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    hvel_d = cfg_hvel_i;
                    vvel_d = cfg_vvel_i;
                    if (cfg_load_pos_i) begin
                        hpos_d = clamp(cfg_hpos_i, HMax);
                        vpos_d = clamp(cfg_vpos_i, VMax);
                    end
                    // Config wins the cycle; a coincident frame edge is deferred.
                    if (frame_edge && run_i) pend_d = 1'b1;
                end else if ((frame_edge || pend_q) && run_i) begin
                    state_d = StUpdate;
                    pend_d  = 1'b0;
                end
            end
            StUpdate: begin
                state_d = StIdle;
                if (frame_edge && run_i) pend_d = 1'b1;
                hpos_d  = h_step.pos;
                hvel_d  = h_step.vel;
                hit_h_d = h_step.hit;
                vpos_d  = v_step.pos;
                vvel_d  = v_step.vel;
                hit_v_d = v_step.hit;
                done_d  = 1'b1;
                cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            vs_q    <= 1'b0;
            pend_q  <= 1'b0;
            hpos_q  <= 9'(INIT_H);
            vpos_q  <= 9'(INIT_V);
            hvel_q  <= 9'(INIT_HVEL);
            vvel_q  <= 9'(INIT_VVEL);
            hit_h_q <= 1'b0;
            hit_v_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            vs_q    <= vsync_i;
            pend_q  <= pend_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hvel_q  <= hvel_d;
            vvel_q  <= vvel_d;
            hit_h_q <= hit_h_d;
            hit_v_q <= hit_v_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cfg_ready_o = (state_q == StIdle);
    assign ball_hpos_o = hpos_q;
    assign ball_vpos_o = vpos_q;
    assign hit_h_o     = hit_h_q;
    assign hit_v_o     = hit_v_q;
    assign done_o      = done_q;
    assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: bounces, walls, config priority, pause and reset abort.
module tb_ball_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync, run, cfg_valid, cfg_load_pos;
    logic [8:0]  cfg_hvel, cfg_vvel, cfg_hpos, cfg_vpos;
    logic        cfg_ready;
    logic [8:0]  hpos, vpos;
    logic        hit_h, hit_v, done;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    ball_motion_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .vsync_i        (vsync),
        .run_i          (run),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_hvel_i     (cfg_hvel),
        .cfg_vvel_i     (cfg_vvel),
        .cfg_load_pos_i (cfg_load_pos),
        .cfg_hpos_i     (cfg_hpos),
        .cfg_vpos_i     (cfg_vpos),
        .ball_hpos_o    (hpos),
        .ball_vpos_o    (vpos),
        .hit_h_o        (hit_h),
        .hit_v_o        (hit_v),
        .done_o         (done),
        .frame_cnt_o    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vsync rise, then step to just after the UPDATE exit edge.
    task automatic frame();
        vsync = 1'b1;
        tick();
        chk("upd_ready", {31'd0, cfg_ready}, 0);
        chk("upd_done", {31'd0, done}, 0);
        vsync = 1'b0;
        tick();
        exp_cnt++;
    endtask

    task automatic chk_frame(input string tag, input int eh, input int ev, input logic ehh,
                             input logic ehv);
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_hpos"}, {23'd0, hpos}, 32'(eh));
        chk({tag, "_vpos"}, {23'd0, vpos}, 32'(ev));
        chk({tag, "_hit_h"}, {31'd0, hit_h}, {31'd0, ehh});
        chk({tag, "_hit_v"}, {31'd0, hit_v}, {31'd0, ehv});
        chk({tag, "_cnt"}, {16'd0, frame_cnt}, 32'(exp_cnt));
    endtask

    task automatic cfg(input int hv, input int vv, input logic ld, input int hp, input int vp);
        cfg_valid    = 1'b1;
        cfg_hvel     = 9'(hv);
        cfg_vvel     = 9'(vv);
        cfg_load_pos = ld;
        cfg_hpos     = 9'(hp);
        cfg_vpos     = 9'(vp);
        tick();
        cfg_valid    = 1'b0;
        cfg_load_pos = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; run = 1'b1; cfg_valid = 1'b0; cfg_load_pos = 1'b0;
        cfg_hvel = '0; cfg_vvel = '0; cfg_hpos = '0; cfg_vpos = '0;
        tick();
        chk("rst_hpos", {23'd0, hpos}, 128);
        chk("rst_vpos", {23'd0, vpos}, 128);
        chk("rst_cnt", {16'd0, frame_cnt}, 0);
        chk("rst_ready", {31'd0, cfg_ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_hits", {30'd0, hit_h, hit_v}, 0);
        rst_n = 1'b1;
        tick();

        // Default velocity (-2,+2) from (128,128)
        frame();
        chk_frame("f1", 126, 130, 1'b0, 1'b0);
        tick();
        chk("f1_done_pulse", {31'd0, done}, 0);

        // Right-wall bounce, then reversed velocity takes effect
        cfg(5, 0, 1'b1, 313, 50);
        chk("ld1_hpos", {23'd0, hpos}, 313);
        chk("ld1_vpos", {23'd0, vpos}, 50);
        frame();
        chk_frame("rwall", 316, 50, 1'b1, 1'b0);
        frame();
        chk_frame("rwall2", 311, 50, 1'b0, 1'b0);

        // Corner bounce at origin on both axes
        cfg(-3, -3, 1'b1, 1, 2);
        frame();
        chk_frame("origin", 0, 0, 1'b1, 1'b1);
        frame();
        chk_frame("origin2", 3, 3, 1'b0, 1'b0);

        // Landing exactly on the far walls is not a bounce; overshooting is
        cfg(3, 3, 1'b1, 313, 233);
        frame();
        chk_frame("exact", 316, 236, 1'b0, 1'b0);
        frame();
        chk_frame("far", 316, 236, 1'b1, 1'b1);
        frame();
        chk_frame("far2", 313, 233, 1'b0, 1'b0);

        // Out-of-range load positions clamp to the far walls
        cfg(0, 0, 1'b1, 400, 300);
        chk("clamp_hpos", {23'd0, hpos}, 316);
        chk("clamp_vpos", {23'd0, vpos}, 236);

        // -256 negates to itself, so it bounces off the left wall every frame
        cfg(-256, 0, 1'b1, 0, 10);
        frame();
        chk_frame("m256a", 0, 10, 1'b1, 1'b0);
        frame();
        chk_frame("m256b", 0, 10, 1'b1, 1'b0);

        // Config and frame edge together: config first, update one cycle later
        cfg_valid = 1'b1; cfg_hvel = 9'd1; cfg_vvel = 9'd1; cfg_load_pos = 1'b1;
        cfg_hpos = 9'd128; cfg_vpos = 9'd128; vsync = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_load_pos = 1'b0;
        chk("coll_ready", {31'd0, cfg_ready}, 1);
        chk("coll_done", {31'd0, done}, 0);
        chk("coll_hpos", {23'd0, hpos}, 128);
        tick();
        chk("coll_upd_ready", {31'd0, cfg_ready}, 0);
        vsync = 1'b0;
        tick();
        exp_cnt++;
        chk_frame("coll", 129, 129, 1'b0, 1'b0);

        // Paused frame edges are dropped
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vsync = 1'b1;
            tick();
            chk("pause_ready", {31'd0, cfg_ready}, 1);
            vsync = 1'b0;
            tick();
            chk("pause_done", {31'd0, done}, 0);
            chk("pause_hpos", {23'd0, hpos}, 129);
        end
        run = 1'b1;
        frame();
        chk_frame("resume", 130, 130, 1'b0, 1'b0);
        tick();
        chk("resume_once", {31'd0, done}, 0);
        tick();
        chk("resume_once2", {31'd0, done}, 0);

        // A deferred edge survives a pause and is serviced on resume
        cfg_valid = 1'b1; cfg_hvel = 9'd1; cfg_vvel = 9'd1; vsync = 1'b1;
        tick();
        cfg_valid = 1'b0; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pend_hold_ready", {31'd0, cfg_ready}, 1);
            chk("pend_hold_done", {31'd0, done}, 0);
        end
        vsync = 1'b0;
        run = 1'b1;
        tick();
        chk("pend_upd_ready", {31'd0, cfg_ready}, 0);
        tick();
        exp_cnt++;
        chk_frame("pend", 131, 131, 1'b0, 1'b0);

        // Reset in the UPDATE cycle aborts the update
        vsync = 1'b1;
        tick();
        chk("abort_in_upd", {31'd0, cfg_ready}, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, cfg_ready}, 1);
        vsync = 1'b0;
        tick();
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_hpos", {23'd0, hpos}, 128);
        chk("abort_vpos", {23'd0, vpos}, 128);
        chk("abort_cnt", {16'd0, frame_cnt}, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_after", {31'd0, done}, 0);
        exp_cnt = 0;
        frame();
        chk_frame("post_rst", 126, 130, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
